// File: rtl/mux_pkg.sv
// mux_pkg
//   Shared definitions for the stream_mux block:
//     sel_w()          - index width for a channel count, never below 1 bit
//     MUX_MAX_CHANNELS - largest supported channel count
//     out_state_t      - EMPTY/FULL encoding of the output register
package mux_pkg;

  localparam int MUX_MAX_CHANNELS = 16;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_t;

  // $clog2(1) is 0, which would give a zero-width index vector.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_arbiter.sv
// mux_arbiter
//   Purely combinational channel arbiter for stream_mux.
//   Build option: STREAM_MUX_ROUND_ROBIN_EN defined selects round-robin search
//   starting after Last; undefined selects fixed priority (lowest index wins).
//   Ports:
//     Req       in   per-channel request (DValid)
//     Last      in   index of the most recently granted channel
//     ForceEn   in   restrict the candidate set to channel Select
//     Select    in   forced channel index (values >= Channels match nothing)
//     GntOneHot out  one-hot grant, all zero when nothing is granted
//     GntIdx    out  index of the granted channel
//     GntValid  out  a channel was granted
module mux_arbiter
  import mux_pkg::*;
#(
  parameter int Channels   = 4,
  parameter int SelectSize = sel_w(Channels)
) (
  input  logic [Channels-1:0]   Req,
  input  logic [SelectSize-1:0] Last,
  input  logic                  ForceEn,
  input  logic [SelectSize-1:0] Select,
  output logic [Channels-1:0]   GntOneHot,
  output logic [SelectSize-1:0] GntIdx,
  output logic                  GntValid
);

`ifdef STREAM_MUX_ROUND_ROBIN_EN
  localparam bit RoundRobin = 1'b1;
`else
  localparam bit RoundRobin = 1'b0;
`endif

  logic [Channels-1:0] cand;

  // With ForceEn the only possible candidate is channel Select; an
  // out-of-range Select matches no k, so the set is empty.
  always_comb begin
    cand = '0;
    for (int k = 0; k < Channels; k++) begin
      cand[k] = Req[k] & (~ForceEn | (int'(Select) == k));
    end
  end

  // One search loop serves both builds: fixed priority is a round-robin
  // search whose starting pointer is pinned at Channels-1, so the scan
  // order is 0, 1, 2, ...
  always_comb begin
    int base;
    int k;
    GntIdx   = '0;
    GntValid = 1'b0;
    base     = RoundRobin ? int'(Last) : (Channels - 1);
    k        = 0;
    for (int i = 1; i <= Channels; i++) begin
      k = (base + i) % Channels;
      if (!GntValid && cand[k]) begin
        GntValid = 1'b1;
        GntIdx   = SelectSize'(k);
      end
    end
  end

  always_comb begin
    GntOneHot = '0;
    for (int j = 0; j < Channels; j++) begin
      GntOneHot[j] = GntValid & (int'(GntIdx) == j);
    end
  end

endmodule

// File: rtl/stream_mux.sv
// stream_mux
//   N-to-1 valid/ready stream multiplexer with a registered output stage.
//   Arbitration is fixed priority by default, round-robin when the macro
//   STREAM_MUX_ROUND_ROBIN_EN is defined. ForceEn steers to one channel.
//   Ports:
//     Clk, Reset  clock and synchronous active-high reset
//     DIn         flattened channel data, channel k at [k*DataWidth +: DataWidth]
//     DValid      per-channel valid
//     DReady      per-channel accept, at most one bit high
//     ForceEn     only channel Select may be granted
//     Select      forced channel index
//     DOut        registered output word
//     OValid      DOut holds a word
//     OReady      consumer accepts DOut
//     Grant       channel index that produced DOut
module stream_mux
  import mux_pkg::*;
#(
  parameter int DataWidth  = 8,
  parameter int Channels   = 4,
  parameter int SelectSize = sel_w(Channels)
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [Channels*DataWidth-1:0] DIn,
  input  logic [Channels-1:0]           DValid,
  output logic [Channels-1:0]           DReady,
  input  logic                          ForceEn,
  input  logic [SelectSize-1:0]         Select,
  output logic [DataWidth-1:0]          DOut,
  output logic                          OValid,
  input  logic                          OReady,
  output logic [SelectSize-1:0]         Grant
);

  out_state_t            state_p0;
  logic [SelectSize-1:0] last_p0;

  logic                  load;
  logic                  accept;
  logic [Channels-1:0]   gnt_onehot;
  logic [SelectSize-1:0] gnt_idx;
  logic                  gnt_vld;
  logic [DataWidth-1:0]  win_data;

  mux_arbiter #(
    .Channels   (Channels),
    .SelectSize (SelectSize)
  ) u_arb (
    .Req       (DValid),
    .Last      (last_p0),
    .ForceEn   (ForceEn),
    .Select    (Select),
    .GntOneHot (gnt_onehot),
    .GntIdx    (gnt_idx),
    .GntValid  (gnt_vld)
  );

  assign OValid = (state_p0 == OUT_FULL);

  // The output register can take a new word when it is empty or when its
  // current word leaves this cycle, so a steady OReady gives no bubbles.
  assign load   = ~OValid | OReady;
  assign accept = load & gnt_vld & ~Reset;
  assign DReady = accept ? gnt_onehot : '0;

  always_comb begin
    win_data = '0;
    for (int k = 0; k < Channels; k++) begin
      if (gnt_onehot[k]) win_data = DIn[k*DataWidth +: DataWidth];
    end
  end

  // ---- stage p0: output register and arbiter pointer ----
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_p0 <= OUT_EMPTY;
      DOut     <= '0;
      Grant    <= '0;
      last_p0  <= SelectSize'(Channels - 1);
    end else if (load) begin
      if (gnt_vld) begin
        state_p0 <= OUT_FULL;
        DOut     <= win_data;
        Grant    <= gnt_idx;
        last_p0  <= gnt_idx;
      end else begin
        // DOut and Grant keep their last values while empty.
        state_p0 <= OUT_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux
//   Directed bench for stream_mux: a 4-channel instance for the main
//   sequence and a 3-channel instance for the out-of-range forced select.
//   Expected grants follow the build: round-robin when
//   STREAM_MUX_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module tb_stream_mux;

`ifdef STREAM_MUX_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  // 4-channel instance
  logic        Reset;
  logic [31:0] DIn;
  logic [3:0]  DValid;
  logic [3:0]  DReady;
  logic        ForceEn;
  logic [1:0]  Select;
  logic [7:0]  DOut;
  logic        OValid;
  logic        OReady;
  logic [1:0]  Grant;

  // 3-channel instance
  logic        Reset3;
  logic [23:0] DIn3;
  logic [2:0]  DValid3;
  logic [2:0]  DReady3;
  logic        ForceEn3;
  logic [1:0]  Select3;
  logic [7:0]  DOut3;
  logic        OValid3;
  logic        OReady3;
  logic [1:0]  Grant3;

  stream_mux #(.DataWidth(8), .Channels(4)) dut (
    .Clk(Clk), .Reset(Reset), .DIn(DIn), .DValid(DValid), .DReady(DReady),
    .ForceEn(ForceEn), .Select(Select), .DOut(DOut), .OValid(OValid),
    .OReady(OReady), .Grant(Grant)
  );

  stream_mux #(.DataWidth(8), .Channels(3)) dut3 (
    .Clk(Clk), .Reset(Reset3), .DIn(DIn3), .DValid(DValid3), .DReady(DReady3),
    .ForceEn(ForceEn3), .Select(Select3), .DOut(DOut3), .OValid(OValid3),
    .OReady(OReady3), .Grant(Grant3)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  int exp_g;
  logic [7:0] prev_dout;
  logic [1:0] prev_grant;

  initial begin
    Reset = 1'b1; DIn = '0; DValid = '0; ForceEn = 1'b0; Select = '0; OReady = 1'b0;
    Reset3 = 1'b1; DIn3 = 24'h333231; DValid3 = '0; ForceEn3 = 1'b0; Select3 = '0;
    OReady3 = 1'b0;

    // Reset state, and no DReady while Reset is high even with requests.
    tick();
    tick();
    DValid = 4'hF; OReady = 1'b1;
    #1;
    chk("rst_dready", 32'(DReady), 32'h0);
    chk("rst_ovalid", 32'(OValid), 32'h0);
    chk("rst_dout", 32'(DOut), 32'h0);
    chk("rst_grant", 32'(Grant), 32'h0);
    tick();
    chk("rst_ovalid_hold", 32'(OValid), 32'h0);

    // All channels requesting, consumer always ready.
    Reset = 1'b0; Reset3 = 1'b0;
    DIn = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    chk("all_dready0", 32'(DReady), 32'h1);
    tick();
    chk("all_ovalid0", 32'(OValid), 32'h1);
    chk("all_dout0", 32'(DOut), 32'hA0);
    chk("all_grant0", 32'(Grant), 32'h0);
    for (int i = 1; i <= 4; i++) begin
      exp_g = RR ? (i % 4) : 0;
      #1;
      chk("all_dready", 32'(DReady), 32'(1) << exp_g);
      tick();
      chk("all_grant", 32'(Grant), 32'(exp_g));
      chk("all_dout", 32'(DOut), 32'hA0 + 32'(exp_g));
      chk("all_ovalid", 32'(OValid), 32'h1);
    end

    // Load 0xA1, then stall the consumer for three cycles.
    DValid = 4'b0010;
    #1;
    chk("ld_a1_dready", 32'(DReady), 32'h2);
    tick();
    chk("ld_a1_dout", 32'(DOut), 32'hA1);
    chk("ld_a1_grant", 32'(Grant), 32'h1);
    OReady = 1'b0; DValid = 4'hF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_dready", 32'(DReady), 32'h0);
      tick();
      chk("stall_ovalid", 32'(OValid), 32'h1);
      chk("stall_dout", 32'(DOut), 32'hA1);
      chk("stall_grant", 32'(Grant), 32'h1);
    end
    // Release: the next word loads on the same edge the held one leaves.
    OReady = 1'b1;
    exp_g = RR ? 2 : 0;
    #1;
    chk("rel_dready", 32'(DReady), 32'(1) << exp_g);
    tick();
    chk("rel_ovalid", 32'(OValid), 32'h1);
    chk("rel_dout", 32'(DOut), 32'hA0 + 32'(exp_g));
    chk("rel_grant", 32'(Grant), 32'(exp_g));
    prev_dout  = 8'hA0 + 8'(exp_g);
    prev_grant = 2'(exp_g);

    // Forced select on channel 2 while channel 2 is idle: nothing granted.
    ForceEn = 1'b1; Select = 2'd2; DValid = 4'b1011;
    #1;
    chk("frc_idle_dready", 32'(DReady), 32'h0);
    tick();
    chk("frc_idle_ovalid", 32'(OValid), 32'h0);
    chk("frc_idle_dout", 32'(DOut), 32'(prev_dout));
    chk("frc_idle_grant", 32'(Grant), 32'(prev_grant));
    #1;
    chk("frc_idle_dready2", 32'(DReady), 32'h0);
    tick();
    chk("frc_idle_ovalid2", 32'(OValid), 32'h0);
    // Channel 2 comes up with 0x5C.
    DIn[23:16] = 8'h5C; DValid = 4'hF;
    #1;
    chk("frc_dready", 32'(DReady), 32'h4);
    tick();
    chk("frc_dout", 32'(DOut), 32'h5C);
    chk("frc_grant", 32'(Grant), 32'h2);
    chk("frc_ovalid", 32'(OValid), 32'h1);

    // Fill with 0x77, then reset while FULL and stalled.
    ForceEn = 1'b0; DIn[7:0] = 8'h77; DValid = 4'b0001;
    #1;
    chk("f77_dready", 32'(DReady), 32'h1);
    tick();
    chk("f77_dout", 32'(DOut), 32'h77);
    chk("f77_grant", 32'(Grant), 32'h0);
    OReady = 1'b0; DValid = 4'hF; Reset = 1'b1;
    #1;
    chk("mid_rst_dready", 32'(DReady), 32'h0);
    tick();
    chk("mid_rst_ovalid", 32'(OValid), 32'h0);
    chk("mid_rst_dout", 32'(DOut), 32'h0);
    chk("mid_rst_grant", 32'(Grant), 32'h0);
    Reset = 1'b0; OReady = 1'b1; DIn = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    #1;
    chk("post_rst_dready", 32'(DReady), 32'h1);
    tick();
    chk("post_rst_grant", 32'(Grant), 32'h0);
    chk("post_rst_dout", 32'(DOut), 32'hA0);

    // Single requester on channel 1, back-to-back.
    DValid = 4'b0010;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("solo_dready", 32'(DReady), 32'h2);
      tick();
      chk("solo_grant", 32'(Grant), 32'h1);
      chk("solo_dout", 32'(DOut), 32'hA1);
      chk("solo_ovalid", 32'(OValid), 32'h1);
    end

    // Three-channel instance: Select=3 is out of range, never granted.
    ForceEn3 = 1'b1; Select3 = 2'd3; OReady3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      case (i)
        0: DValid3 = 3'b111;
        1: DValid3 = 3'b001;
        2: DValid3 = 3'b010;
        3: DValid3 = 3'b100;
        default: DValid3 = 3'b011;
      endcase
      #1;
      chk("oor_dready", 32'(DReady3), 32'h0);
      tick();
      chk("oor_ovalid", 32'(OValid3), 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/stream_mux.md
# stream_mux

Parametrised N-to-1 multiplexer with valid/ready handshakes on every input channel and a registered output stage. It replaces the combinational 4:1 select mux where sources are independent producers. It arbitrates among requesting channels, round-robin or fixed priority, and keeps a forced-select mode for legacy steering. It sits between multiple producer blocks and a single downstream consumer.

## Interface
- DataWidth, 8, bits per channel word
- Channels, 4, number of input channels (2..16)
- SelectSize, $clog2(Channels), width of Select and Grant
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high reset
- DIn  in  Channels*DataWidth  flattened channel data; channel k at [k*DataWidth +: DataWidth]
- DValid  in  Channels  per-channel word valid
- DReady  out  Channels  per-channel accept; at most one bit high
- ForceEn  in  1  1 = only channel Select may be granted
- Select  in  SelectSize  forced channel index
- DOut  out  DataWidth  registered output word
- OValid  out  1  DOut holds a word
- OReady  in  1  consumer accepts DOut
- Grant  out  SelectSize  channel index that produced DOut

## Operation
- Output register states: EMPTY (OValid=0) and FULL (OValid=1).
- Load = ~OValid | OReady. Load is evaluated combinationally every cycle.
- Candidate set:
  - ForceEn=0: all k with DValid[k]=1.
  - ForceEn=1: {Select} if Select<Channels and DValid[Select]=1, otherwise empty.
- Select >= Channels with ForceEn=1 grants nothing. This is the successor of the old zero-output default.
- When Load=1 and the candidate set is non-empty:
  - The arbiter picks channel g.
  - DReady[g]=1 and all other DReady bits are 0.
  - Next edge: DOut <= DIn[g], Grant <= g, OValid <= 1.
- When Load=1 and the candidate set is empty: next edge OValid <= 0. DOut and Grant hold their previous values.
- When Load=0 (FULL and OReady=0): all DReady=0, and DOut, Grant and OValid hold.
- DReady depends combinationally on DValid, OReady, ForceEn, Select and arbiter state.
- A producer must hold DIn and DValid until it sees DReady high. A consumer may hold OReady high permanently.
- Arbiter pointer Last (SelectSize bits) is updated to g on every accepted grant, forced grants included.
- Round-robin search order is Last+1, Last+2, …, wrapping from Channels-1 to 0.

## Timing
- Latency: 1 cycle from the DValid&DReady edge to OValid/DOut.
- Throughput: 1 word per cycle when OReady is held high.
- Reset values:
  - OValid=0, DOut=0, Grant=0.
  - Last=Channels-1, so channel 0 has first priority.
  - DReady=0 for the duration of the Reset cycle.
- Reset asserted mid-transfer discards the word held in the output register. No DReady is asserted while Reset=1.
- A change to ForceEn or Select takes effect on the next Load cycle. A word already in the output register is not affected.
- Simultaneous OReady and a new grant in the same cycle: the old word leaves and the new word loads. There is no bubble.

## Configuration
- STREAM_MUX_ROUND_ROBIN_EN defined: round-robin search from Last+1 as above.
- Not defined: fixed priority, where the lowest index wins. Last is still maintained but not used for selection.
- ForceEn behaves identically in both builds.

## Structure
- Package mux_pkg holds:
  - function clog2-safe width helper
  - localparam MUX_MAX_CHANNELS = 16
  - the typedef of the EMPTY/FULL state encoding
- Sub-module mux_arbiter takes Channels, Req, Last and ForceEn/Select, and returns a one-hot grant plus its index. It is purely combinational.
- stream_mux owns the output register, the Last register and the DReady generation.

## Test plan
- Reset, then DValid=4'b1111 with DIn words 0xA0..0xA3 and OReady=1.
  - Round-robin: Grant sequence 0,1,2,3,0; DOut 0xA0,0xA1,… one per cycle.
  - Fixed priority: Grant stays 0.
- OReady=0 for 3 cycles while FULL with 0xA1: DOut=0xA1 stable, all DReady=0, OValid=1. OReady=1 then releases it, and the next word loads on the same edge.
- ForceEn=1, Select=2, DValid=4'b1011: no grant, OValid falls to 0. Raising DValid[2] with DIn 0x5C gives DOut=0x5C, Grant=2 one cycle later.
- ForceEn=1, Select=3 with Channels=3: no DReady ever, OValid=0, regardless of DValid.
- Reset asserted while FULL with 0x77 and OReady=0: next cycle OValid=0, DOut=0, Grant=0, and the first post-reset grant goes to channel 0.
- Only DValid[1] high for 5 cycles with OReady=1: Grant=1 each cycle, DReady[1]=1 continuously, no bubbles.
